// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared constants and helpers for the 4-digit 7-segment scan driver.
//   NUM_DIGITS   : number of multiplexed digits
//   AN_ALL_OFF   : active-low anode pattern with every digit dark
//   nibble_sel   : pick nibble idx out of a 16-bit display word
//   anode_onehot : active-high one-hot for digit idx (invert for the pins)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package disp_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  // Nibble n occupies bits [4n+3:4n].
  function automatic logic [3:0] nibble_sel(input logic [15:0] word,
                                            input logic [1:0]  idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] anode_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/digit_scan_driver_slot_timer.sv
// ---------------------------------------------------------------------------
// slot_timer
// Free-running slot counter and digit index for the scan driver.
//   clk, reset  : clock, asynchronous active-high reset
//   idx         : digit currently being scanned (0..3)
//   blank       : current cycle lies in the anode blanking interval
//   slot_end    : last cycle of the current digit slot
//   frame_end   : last cycle of the last slot (frame boundary edge)
// blank/slot_end/frame_end are combinational decodes of the state; the
// top level registers everything that reaches a pin.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module slot_timer
  import disp_pkg::*;
#(
  parameter int REFRESH_TICKS = 16000,
  parameter int BLANK_TICKS   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx,
  output logic       blank,
  output logic       slot_end,
  output logic       frame_end
);

  localparam int               CNT_W   = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_TICKS);
  localparam logic [1:0]       IDX_MAX = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == IDX_MAX);
    blank     = (cnt_q < BLANK_C);

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      // Two-bit index wraps 3 -> 0 on its own.
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/digit_scan_driver.sv
// ---------------------------------------------------------------------------
// digit_scan_driver
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   load        : one-cycle write strobe for data_in (always accepted)
//   data_in     : new display word, nibble n in bits [4n+3:4n]
//   pending     : a written word waits for the next frame boundary
//   char        : nibble of the digit being scanned, to the hex decoder
//   an          : active-low anode enables, an[n] drives digit n
//   frame_start : one-cycle pulse as each new frame begins
// Host writes land in a shadow register and are copied to the displayed
// word only at a frame boundary, so a frame never mixes two words. Each
// slot opens with a blanking interval so the previous digit's segments
// are not briefly shown on the next anode.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module digit_scan_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_TICKS = 16000,
  parameter int BLANK_TICKS   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic        pending,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_start
);

  logic [1:0] idx;
  logic       blank;
  logic       frame_end;
  // Slot-end strobe is not needed here; kept on the timer for observability.
  logic       unused_slot_end;

  slot_timer #(
    .REFRESH_TICKS (REFRESH_TICKS),
    .BLANK_TICKS   (BLANK_TICKS)
  ) u_slot_timer (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .blank     (blank),
    .slot_end  (unused_slot_end),
    .frame_end (frame_end)
  );

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] disp_q,   disp_d;
  logic        pending_q, pending_d;
  logic [3:0]  an_q,     an_d;
  logic [3:0]  char_q,   char_d;
  logic        frame_start_q, frame_start_d;

  // Buffer management: a load on the boundary edge goes straight to the
  // display so it is neither lost nor delayed by a whole frame.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;

    if (frame_end) begin
      if (load) begin
        shadow_d  = data_in;
        disp_d    = data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

  // Output registers: one cycle behind cnt/idx. char tracks idx even while
  // blanked so the decoder has settled before the anode turns on.
  always_comb begin
    an_d          = blank ? AN_ALL_OFF : ~anode_onehot(idx);
    char_d        = nibble_sel(disp_q, idx);
    frame_start_d = frame_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q      <= '0;
      disp_q        <= '0;
      pending_q     <= 1'b0;
      an_q          <= AN_ALL_OFF;
      char_q        <= 4'h0;
      frame_start_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      char_q        <= char_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pending     = pending_q;
  assign char        = char_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
`timescale 1ns/1ps
module tb_digit_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        pending;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  // Number of rising edges since the last reset release.
  int edge_k   = 0;

  digit_scan_driver #(.REFRESH_TICKS(8), .BLANK_TICKS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .data_in     (data_in),
    .pending     (pending),
    .char        (char),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_k++;
  endtask

  task automatic run_to(input int k);
    while (edge_k < k) tick();
  endtask

  // Expected anode pattern after edge k: blank for the first two cycles
  // of each 8-cycle slot, then digit ((k-1)/8)%4 active low.
  function automatic logic [3:0] exp_an(input int k);
    int pos, slot;
    pos  = (k - 1) % 8;
    slot = ((k - 1) / 8) % 4;
    if (pos < 2) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [3:0] exp_char(input int k, input logic [15:0] w);
    int slot;
    slot = ((k - 1) / 8) % 4;
    return w[slot*4 +: 4];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    load = 1'b1;
    data_in = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rst_an got %b want 1111", an); end
    n_checks++; if (char !== 4'h0) begin n_fail++; $display("FAIL rst_char got %h want 0", char); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %b want 0", pending); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start got %b want 0", frame_start); end
    load = 1'b0;
    data_in = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    edge_k = 0;
    tick();
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending_after got %b want 0", pending); end
    run_to(32);
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rst_first_boundary got %b want 1", frame_start); end
    run_to(35);
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL rst_disp_an got %b want 1110", an); end
    n_checks++; if (char !== 4'h0) begin n_fail++; $display("FAIL rst_disp_char got %h want 0 (ignored load)", char); end
  endtask

  task automatic test_load_transfer();
    // Fresh release so edge numbering matches the plan.
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    edge_k = 0;
    run_to(2);
    load = 1'b1;
    data_in = 16'h1234;
    tick();
    load = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_set got %b want 1", pending); end
    run_to(31);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_hold got %b want 1", pending); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL load_fs_early got %b want 0", frame_start); end
    n_checks++; if (char !== 4'h0) begin n_fail++; $display("FAIL load_char_old got %h want 0", char); end
    tick();
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL load_pending_clr got %b want 0", pending); end
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL load_fs got %b want 1", frame_start); end
    tick();
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL load_fs_pulse got %b want 0", frame_start); end
    n_checks++; if (an !== 4'b1111 || char !== 4'h4) begin n_fail++; $display("FAIL load_blank33 got an=%b char=%h want 1111/4", an, char); end
    run_to(35);
    n_checks++; if (an !== 4'b1110 || char !== 4'h4) begin n_fail++; $display("FAIL load_dig0 got an=%b char=%h want 1110/4", an, char); end
    run_to(43);
    n_checks++; if (an !== 4'b1101 || char !== 4'h3) begin n_fail++; $display("FAIL load_dig1 got an=%b char=%h want 1101/3", an, char); end
    run_to(51);
    n_checks++; if (an !== 4'b1011 || char !== 4'h2) begin n_fail++; $display("FAIL load_dig2 got an=%b char=%h want 1011/2", an, char); end
    run_to(59);
    n_checks++; if (an !== 4'b0111 || char !== 4'h1) begin n_fail++; $display("FAIL load_dig3 got an=%b char=%h want 0111/1", an, char); end
  endtask

  task automatic test_blanking();
    run_to(64);
    for (int i = 0; i < 96; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(edge_k) || char !== exp_char(edge_k, 16'h1234)) begin
        n_fail++;
        $display("FAIL blank_scan edge %0d got an=%b char=%h want %b/%h",
                 edge_k, an, char, exp_an(edge_k), exp_char(edge_k, 16'h1234));
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL blank_onehot edge %0d got an=%b want at most one low", edge_k, an);
      end
    end
  endtask

  task automatic test_overwrite();
    run_to(164);
    load = 1'b1; data_in = 16'hAAAA;
    tick();
    load = 1'b0;
    run_to(169);
    load = 1'b1; data_in = 16'h5B5B;
    tick();
    load = 1'b0;
    run_to(191);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL ovw_pending got %b want 1", pending); end
    tick();
    n_checks++; if (pending !== 1'b0 || frame_start !== 1'b1) begin n_fail++; $display("FAIL ovw_boundary got pend=%b fs=%b want 0/1", pending, frame_start); end
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(edge_k) || char !== exp_char(edge_k, 16'h5B5B)) begin
        n_fail++;
        $display("FAIL ovw_scan edge %0d got an=%b char=%h want %b/%h",
                 edge_k, an, char, exp_an(edge_k), exp_char(edge_k, 16'h5B5B));
      end
      n_checks++;
      if (an !== 4'b1111 && char === 4'hA) begin
        n_fail++;
        $display("FAIL ovw_stale edge %0d got char=%h want not A", edge_k, char);
      end
    end
  endtask

  task automatic test_load_on_boundary();
    run_to(255);
    load = 1'b1; data_in = 16'hC0DE;
    tick();
    load = 1'b0;
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL bnd_pending got %b want 0", pending); end
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL bnd_fs got %b want 1", frame_start); end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(edge_k) || char !== exp_char(edge_k, 16'hC0DE)) begin
        n_fail++;
        $display("FAIL bnd_scan edge %0d got an=%b char=%h want %b/%h",
                 edge_k, an, char, exp_an(edge_k), exp_char(edge_k, 16'hC0DE));
      end
    end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL bnd_pending_end got %b want 0", pending); end
  endtask

  task automatic test_async_reset();
    run_to(318);
    load = 1'b1; data_in = 16'h0900;
    tick();
    load = 1'b0;
    run_to(341);
    n_checks++; if (an !== 4'b1011 || char !== 4'h9) begin n_fail++; $display("FAIL arst_pre got an=%b char=%h want 1011/9", an, char); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL arst_an got %b want 1111", an); end
    n_checks++; if (char !== 4'h0) begin n_fail++; $display("FAIL arst_char got %h want 0", char); end
    n_checks++; if (pending !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl got pend=%b fs=%b want 0/0", pending, frame_start); end
    @(negedge clk);
    reset = 1'b0;
    edge_k = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(edge_k) || char !== 4'h0) begin
        n_fail++;
        $display("FAIL arst_restart edge %0d got an=%b char=%h want %b/0",
                 edge_k, an, char, exp_an(edge_k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_transfer();
    test_blanking();
    test_overwrite();
    test_load_on_boundary();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
